// File: rtl/mac_tx.sv
// Ethernet MAC transmit framer. Takes a byte stream starting at the
// destination address, wraps it with preamble and SFD, pads short frames,
// appends the CRC-32 FCS and enforces the inter-packet gap on the MII/GMII
// side. Upstream underruns abort the frame with a single txer cycle.
//
// Handshake: a byte moves from upstream on a rising edge where in_valid and
// out_ready are both high. out_ready depends only on the current state (high
// in DATA), never on in_valid, so the upstream side may drive in_valid from
// out_ready without forming a combinational loop. In_valid low in DATA is an
// underrun, not a stall.
module mac_tx #(
    parameter int MIN_PAYLOAD = 60,
    parameter int IPG         = 12
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    input  logic       in_last,
    output logic       out_ready,
    output logic       out_txen,
    output logic [7:0] out_txd,
    output logic       out_txer,
    output logic       out_busy
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_SFD,
        ST_DATA,
        ST_PAD,
        ST_FCS,
        ST_IPG
    } state_t;

    localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY = 32'hEDB8_8320;
    localparam logic [10:0] CNT_MAX  = 11'd2047;
    localparam logic [10:0] MIN_CNT  = 11'(MIN_PAYLOAD);
    localparam logic [15:0] IPG_LAST = 16'(IPG - 1);
    // The IDLE->PRE edge already emits the first preamble byte, so PRE
    // itself only covers the remaining six.
    localparam logic [15:0] PRE_LAST = 16'd5;

    state_t      state, state_nxt;
    logic [15:0] phase_cnt, phase_nxt;   // PRE / FCS / IPG cycle counter
    logic [10:0] byte_cnt, byte_cnt_nxt; // saturating DA..pad byte count
    logic [10:0] cnt_inc;
    logic [31:0] crc, crc_nxt;
    logic        txen_nxt;
    logic [7:0]  txd_nxt;
    logic        txer_nxt;

    // One reflected CRC-32 step per transmitted byte, LSB first.
    function automatic logic [31:0] crc_byte(input logic [31:0] c_in,
                                             input logic [7:0]  d);
        logic [31:0] c;
        c = c_in;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ d[i]) c = (c >> 1) ^ CRC_POLY;
            else             c = c >> 1;
        end
        return c;
    endfunction

    assign out_ready = (state == ST_DATA);
    assign out_busy  = (state != ST_IDLE);

    // Next-state and next-output decode; outputs are registered with the state.
    always_comb begin
        state_nxt    = state;
        phase_nxt    = phase_cnt;
        byte_cnt_nxt = byte_cnt;
        crc_nxt      = crc;
        txen_nxt     = 1'b0;
        txd_nxt      = 8'h00;
        txer_nxt     = 1'b0;
        cnt_inc      = (byte_cnt == CNT_MAX) ? byte_cnt : byte_cnt + 11'd1;
        unique case (state)
            ST_IDLE: begin
                if (in_valid) begin
                    state_nxt    = ST_PRE;
                    phase_nxt    = '0;
                    byte_cnt_nxt = '0;
                    crc_nxt      = CRC_INIT;
                    txen_nxt     = 1'b1;
                    txd_nxt      = 8'h55;
                end
            end
            ST_PRE: begin
                txen_nxt = 1'b1;
                txd_nxt  = 8'h55;
                if (phase_cnt == PRE_LAST) state_nxt = ST_SFD;
                else                       phase_nxt = phase_cnt + 16'd1;
            end
            ST_SFD: begin
                txen_nxt  = 1'b1;
                txd_nxt   = 8'hD5;
                state_nxt = ST_DATA;
            end
            ST_DATA: begin
                txen_nxt  = 1'b1;
                phase_nxt = '0;
                if (in_valid) begin
                    txd_nxt      = in_data;
                    crc_nxt      = crc_byte(crc, in_data);
                    byte_cnt_nxt = cnt_inc;
                    if (in_last) state_nxt = (cnt_inc < MIN_CNT) ? ST_PAD : ST_FCS;
                end else begin
                    // Underrun: poison the frame on the wire, skip the FCS.
                    txer_nxt  = 1'b1;
                    state_nxt = ST_IPG;
                end
            end
            ST_PAD: begin
                txen_nxt     = 1'b1;
                crc_nxt      = crc_byte(crc, 8'h00);
                byte_cnt_nxt = cnt_inc;
                phase_nxt    = '0;
                if (cnt_inc >= MIN_CNT) state_nxt = ST_FCS;
            end
            ST_FCS: begin
                txen_nxt = 1'b1;
                unique case (phase_cnt[1:0])
                    2'd0: txd_nxt = ~crc[7:0];
                    2'd1: txd_nxt = ~crc[15:8];
                    2'd2: txd_nxt = ~crc[23:16];
                    default: txd_nxt = ~crc[31:24];
                endcase
                if (phase_cnt[1:0] == 2'd3) begin
                    state_nxt = ST_IPG;
                    phase_nxt = '0;
                end else begin
                    phase_nxt = phase_cnt + 16'd1;
                end
            end
            ST_IPG: begin
                if (phase_cnt == IPG_LAST) state_nxt = ST_IDLE;
                else                       phase_nxt = phase_cnt + 16'd1;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State, counters, CRC and PHY outputs; reset truncates any frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            phase_cnt <= '0;
            byte_cnt  <= '0;
            crc       <= CRC_INIT;
            out_txen  <= 1'b0;
            out_txd   <= 8'h00;
            out_txer  <= 1'b0;
        end else begin
            state     <= state_nxt;
            phase_cnt <= phase_nxt;
            byte_cnt  <= byte_cnt_nxt;
            crc       <= crc_nxt;
            out_txen  <= txen_nxt;
            out_txd   <= txd_nxt;
            out_txer  <= txer_nxt;
        end
    end

endmodule

// File: tb/tb_mac_tx.sv
// Bench for mac_tx: expected wire traffic per frame is built from the frame
// contents (preamble, SFD, payload, zero pad, CRC, gap) and compared cycle by
// cycle against the PHY outputs.
module tb_mac_tx;

    localparam int MIN_P = 60;
    localparam int IPG_N = 12;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_last = 1'b0;
    logic       out_ready, out_txen, out_txer, out_busy;
    logic [7:0] out_txd;

    // Second instance with no minimum length, for the check-value frame.
    logic       in_valid_z = 1'b0;
    logic [7:0] in_data_z = 8'h00;
    logic       in_last_z = 1'b0;
    logic       out_ready_z, out_txen_z, out_txer_z, out_busy_z;
    logic [7:0] out_txd_z;

    int tests_run = 0;
    int tests_failed = 0;

    logic [9:0] exp_q[$];   // {txer, txen, txd} per cycle
    logic [7:0] obs_q[$];   // bytes seen while txen high
    logic [7:0] pl[0:2199];
    int         acc_cnt;
    int         txen_cnt;

    mac_tx #(.MIN_PAYLOAD(MIN_P), .IPG(IPG_N)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .out_ready(out_ready), .out_txen(out_txen),
        .out_txd(out_txd), .out_txer(out_txer), .out_busy(out_busy)
    );

    mac_tx #(.MIN_PAYLOAD(0), .IPG(IPG_N)) u_dut_z (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_z), .in_data(in_data_z),
        .in_last(in_last_z), .out_ready(out_ready_z), .out_txen(out_txen_z),
        .out_txd(out_txd_z), .out_txer(out_txer_z), .out_busy(out_busy_z)
    );

    // clock
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_crc(input logic [31:0] c_in, input logic [7:0] d);
        logic [31:0] c;
        c = c_in;
        for (int i = 0; i < 8; i++)
            c = ((c[0] ^ d[i]) != 1'b0) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        return c;
    endfunction

    // Reference model: whole frame as seen on the wire, one entry per cycle.
    task automatic build_expected(input int len, input int under);
        logic [7:0]  body[$];
        logic [31:0] c;
        exp_q.delete();
        repeat (7) exp_q.push_back({1'b0, 1'b1, 8'h55});
        exp_q.push_back({1'b0, 1'b1, 8'hD5});
        if (under >= 0) begin
            for (int i = 0; i < under; i++) exp_q.push_back({1'b0, 1'b1, pl[i]});
            exp_q.push_back({1'b1, 1'b1, 8'h00});
        end else begin
            for (int i = 0; i < len; i++) body.push_back(pl[i]);
            while (body.size() < MIN_P) body.push_back(8'h00);
            c = 32'hFFFFFFFF;
            foreach (body[i]) begin
                c = ref_crc(c, body[i]);
                exp_q.push_back({1'b0, 1'b1, body[i]});
            end
            c = ~c;
            for (int b = 0; b < 4; b++) exp_q.push_back({1'b0, 1'b1, c[8*b +: 8]});
        end
        repeat (IPG_N) exp_q.push_back({1'b0, 1'b0, 8'h00});
    endtask

    // Drive one frame from IDLE and compare every output cycle to the model.
    // under >= 0 drops in_valid after that many bytes; keep holds in_valid
    // high after the last byte so the next frame queues up behind this one.
    task automatic run_frame(input int len, input int under, input bit keep);
        int         idx, bad, first_bad, exp_acc;
        logic [9:0] got, first_got, first_exp;
        logic       rdy, vld, busy0;
        build_expected(len, under);
        obs_q.delete();
        acc_cnt = 0; txen_cnt = 0; bad = 0; first_bad = 0;
        first_got = '0; first_exp = '0; busy0 = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; in_data = pl[0]; in_last = (len == 1); idx = 0;
        for (int k = 0; k < exp_q.size(); k++) begin
            rdy = out_ready; vld = in_valid;
            @(posedge clk);
            if (rdy && vld) begin acc_cnt++; idx++; end
            @(negedge clk);
            got = {out_txer, out_txen, out_txd};
            if (k == 0) busy0 = out_busy;
            if (out_txen) begin txen_cnt++; obs_q.push_back(out_txd); end
            if (got !== exp_q[k]) begin
                if (bad == 0) begin first_bad = k; first_got = got; first_exp = exp_q[k]; end
                bad++;
            end
            if (idx >= len) begin
                in_valid = keep; in_last = 1'b0; in_data = 8'($urandom_range(0, 255));
            end else if (idx == under) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1; in_data = pl[idx]; in_last = (idx == len - 1);
            end
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL frame_stream len=%0d under=%0d cycle=%0d got={txer,txen,txd}=%03h expected=%03h (%0d bad cycles)",
                     len, under, first_bad, first_got, first_exp, bad);
        end
        exp_acc = (under >= 0) ? under : len;
        tests_run++;
        if (acc_cnt !== exp_acc) begin
            tests_failed++;
            $display("FAIL accept_count len=%0d got=%0d expected=%0d", len, acc_cnt, exp_acc);
        end
        tests_run++;
        if (busy0 !== 1'b1) begin
            tests_failed++;
            $display("FAIL busy_in_frame got=%b expected=1", busy0);
        end
        if (!keep) begin
            tests_run++;
            if (out_busy !== 1'b0 || out_txen !== 1'b0) begin
                tests_failed++;
                $display("FAIL idle_after_gap busy=%b txen=%b expected 0/0", out_busy, out_txen);
            end
        end
    endtask

    task automatic fill_random(input int len);
        for (int i = 0; i < len; i++) pl[i] = 8'($urandom_range(0, 255));
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; in_data = 8'hAA;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if ({out_txen, out_txd, out_txer, out_ready, out_busy} !== 12'h000) begin
            tests_failed++;
            $display("FAIL reset_outputs got txen=%b txd=%02h txer=%b ready=%b busy=%b expected all 0",
                     out_txen, out_txd, out_txer, out_ready, out_busy);
        end
        in_valid = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_min_frame();
        logic [31:0] c;
        pl[0] = 8'hAB;
        run_frame(1, -1, 1'b0);
        tests_run++;
        if (txen_cnt !== 72) begin
            tests_failed++;
            $display("FAIL min_frame_txen got=%0d expected=72", txen_cnt);
        end
        c = 32'hFFFFFFFF;
        for (int i = 8; i < obs_q.size(); i++) c = ref_crc(c, obs_q[i]);
        tests_run++;
        if (c !== 32'hDEBB20E3) begin
            tests_failed++;
            $display("FAIL min_frame_residue got=%08h expected=deb b20e3", c);
        end
    endtask

    task automatic test_no_pad();
        fill_random(100);
        run_frame(100, -1, 1'b0);
        tests_run++;
        if (txen_cnt !== 112) begin
            tests_failed++;
            $display("FAIL no_pad_txen got=%0d expected=112", txen_cnt);
        end
    endtask

    task automatic test_boundaries();
        int lens[3] = '{59, 60, 61};
        foreach (lens[i]) begin
            fill_random(lens[i]);
            run_frame(lens[i], -1, 1'b0);
        end
    endtask

    task automatic test_underrun();
        fill_random(30);
        run_frame(30, 10, 1'b0);
        tests_run++;
        if (txen_cnt !== 19) begin
            tests_failed++;
            $display("FAIL underrun_txen got=%0d expected=19", txen_cnt);
        end
    endtask

    task automatic test_random();
        int len, under;
        for (int n = 0; n < 10; n++) begin
            len = $urandom_range(1, 200);
            under = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len - 1) : -1;
            fill_random(len);
            run_frame(len, under, 1'b0);
        end
    endtask

    task automatic test_long();
        fill_random(2100);
        run_frame(2100, -1, 1'b0);
        tests_run++;
        if (txen_cnt !== 2112) begin
            tests_failed++;
            $display("FAIL long_frame_txen got=%0d expected=2112", txen_cnt);
        end
    endtask

    task automatic test_back_to_back();
        fill_random(70);
        run_frame(70, -1, 1'b1);
        @(posedge clk);
        @(negedge clk);
        tests_run++;
        if ({out_txer, out_txen, out_txd} !== {1'b0, 1'b1, 8'h55}) begin
            tests_failed++;
            $display("FAIL back_to_back_restart got={txer,txen,txd}=%03h expected=155",
                     {out_txer, out_txen, out_txd});
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_frame();
        @(negedge clk);
        in_valid = 1'b1; in_last = 1'b0; in_data = 8'h3C;
        repeat (15) @(negedge clk);
        tests_run++;
        if (out_txen !== 1'b1 || out_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_frame_active txen=%b ready=%b expected 1/1", out_txen, out_ready);
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if ({out_txen, out_txd, out_txer, out_ready, out_busy} !== 12'h000) begin
            tests_failed++;
            $display("FAIL async_reset got txen=%b txd=%02h txer=%b ready=%b busy=%b expected all 0",
                     out_txen, out_txd, out_txer, out_ready, out_busy);
        end
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        fill_random(8);
        run_frame(8, -1, 1'b0);
    endtask

    task automatic test_min_zero();
        logic [7:0] s[0:8] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        logic [7:0] fcs_exp[0:3] = '{8'h26, 8'h39, 8'hF4, 8'hCB};
        logic [7:0] seen[$];
        int         idx, txer_hits;
        logic       rdy, vld;
        idx = 0; txer_hits = 0;
        @(negedge clk);
        in_valid_z = 1'b1; in_data_z = s[0]; in_last_z = 1'b0;
        for (int k = 0; k < 40; k++) begin
            rdy = out_ready_z; vld = in_valid_z;
            @(posedge clk);
            if (rdy && vld) idx++;
            @(negedge clk);
            if (out_txen_z) seen.push_back(out_txd_z);
            if (out_txer_z) txer_hits++;
            if (idx >= 9) begin
                in_valid_z = 1'b0; in_last_z = 1'b0;
            end else begin
                in_data_z = s[idx]; in_last_z = (idx == 8);
            end
        end
        tests_run++;
        if (seen.size() !== 21 || txer_hits !== 0) begin
            tests_failed++;
            $display("FAIL check_frame_len got=%0d txer=%0d expected=21 txer=0", seen.size(), txer_hits);
        end else begin
            for (int b = 0; b < 4; b++) begin
                tests_run++;
                if (seen[17 + b] !== fcs_exp[b]) begin
                    tests_failed++;
                    $display("FAIL check_fcs_byte%0d got=%02h expected=%02h", b, seen[17 + b], fcs_exp[b]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_min_frame();
        test_no_pad();
        test_boundaries();
        test_underrun();
        test_random();
        test_long();
        test_back_to_back();
        test_reset_mid_frame();
        test_min_zero();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
